ftdi_fifo_emu: RTL
==================

FTDI_FIFO_EMU -- requirements
Module: ftdi_fifo_emu

Interface
REQ-001 SHALL have parameter DEPTH, default 16: entries per FIFO, power of two, 2..256.
REQ-002 SHALL have parameter RXF_GAP, default 3: clocks in_ftdi_rxf_n held high after each read strobe.
REQ-003 SHALL have parameter TXE_GAP, default 3: clocks in_ftdi_txe_n held high after each write strobe.
REQ-004 SHALL have in_ext_osc, input, 1: sole clock; all logic on rising edge.
REQ-005 SHALL have in_reset, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have io_ftdi_data, inout, 8: FT245-style data bus, device side.
REQ-007 SHALL have in_ftdi_rd_n, input, 1: read strobe from host, asynchronous, active-low.
REQ-008 SHALL have in_ftdi_wr_n, input, 1: write strobe from host, asynchronous, active-low.
REQ-009 SHALL have out_ftdi_rxf_n / out_ftdi_txe_n, output, 1 each: RX-data-available / TX-space-available, active-low.
REQ-010 SHALL have in_load_valid, in_load_data[7:0], out_load_ready: local push port into RX FIFO.
REQ-011 SHALL have out_drain_valid, out_drain_data[7:0], in_drain_ready: local pop port from TX FIFO.

Function
REQ-012 SHALL pass in_ftdi_rd_n and in_ftdi_wr_n through 2-flop synchronizers; edge detection uses synchronized values only.
REQ-013 SHALL implement read FSM states R_IDLE, R_DRIVE, R_GAP.
REQ-014 R_IDLE: out_ftdi_rxf_n = 0 iff RX FIFO non-empty; synchronized rd_n falling with FIFO non-empty -> R_DRIVE.
REQ-015 R_DRIVE: io_ftdi_data driven with RX FIFO head; out_ftdi_rxf_n stays 0; synchronized rd_n rising -> pop one entry, R_GAP, bus released same cycle.
REQ-016 R_GAP: out_ftdi_rxf_n = 1 for exactly RXF_GAP clocks, then R_IDLE.
REQ-017 rd_n falling while RX FIFO empty SHALL be ignored; bus stays high-Z; no underflow.
REQ-018 io_ftdi_data SHALL be high-Z in every state except R_DRIVE.
REQ-019 SHALL implement write FSM states W_IDLE, W_STROBE, W_GAP.
REQ-020 W_IDLE: out_ftdi_txe_n = 0 iff TX FIFO not full; synchronized wr_n falling with space -> W_STROBE.
REQ-021 W_STROBE: on synchronized wr_n rising, push the io_ftdi_data value sampled in the final synchronized-low cycle, then W_GAP.
REQ-022 W_GAP: out_ftdi_txe_n = 1 for exactly TXE_GAP clocks, then W_IDLE.
REQ-023 wr_n strobe while TX FIFO full SHALL be dropped; no overflow; no state change.
REQ-024 out_load_ready = RX FIFO not full; push when in_load_valid & out_load_ready.
REQ-025 out_drain_valid = TX FIFO non-empty; pop when out_drain_valid & in_drain_ready; out_drain_data = head, first-word-fall-through.
REQ-026 Simultaneous push and pop on one FIFO SHALL both take effect; occupancy unchanged; full FIFO with pop accepts push.
REQ-027 FIFO pointers SHALL be log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; full/empty from MSB compare.
REQ-028 Both FSMs run independently; concurrent read and write strobes SHALL both be serviced.

Reset
REQ-029 in_reset SHALL empty both FIFOs, set both FSMs to IDLE and synchronizers to 1.
REQ-030 During/after reset: out_ftdi_rxf_n = 1, out_ftdi_txe_n = 0, out_load_ready = 1, out_drain_valid = 0, io_ftdi_data high-Z.
REQ-031 Reset mid-strobe SHALL abort it with no push/pop; host strobe still low after reset is treated as not started until next falling edge.

Configuration
REQ-032 With FTDI_EMU_LOOPBACK_EN defined: each byte pushed into TX FIFO SHALL also be pushed into RX FIFO same cycle if RX FIFO not full, with priority over load port (out_load_ready = 0 that cycle); without it, RX FIFO fed only by load port.

Structure
REQ-033 Package ftdi_emu_pkg SHALL hold read/write FSM state enums and default gap constants.
REQ-034 Both FIFOs SHALL be instances of one sub-module ftdi_emu_fifo (synchronous, parameter DEPTH, width 8).

Verification
REQ-035 Reset, load 0x00..0x03, four rd_n pulses (60 ns low) -> bus shows 0x00,0x01,0x02,0x03; rxf_n high RXF_GAP clocks after each; rxf_n = 1 after last.
REQ-036 rd_n pulse with RX FIFO empty -> bus high-Z throughout, rxf_n stays 1, FIFO pointers unchanged.
REQ-037 Host writes 0xA5, 0x5A -> drain port yields 0xA5 then 0x5A; txe_n high TXE_GAP clocks after each strobe.
REQ-038 DEPTH+1 writes without drain -> txe_n = 1 after DEPTH-th; extra byte dropped; drain returns exactly DEPTH bytes.
REQ-039 in_reset asserted during R_DRIVE -> bus high-Z next clock, rxf_n = 1, RX FIFO empty, no pop count.
REQ-040 With FTDI_EMU_LOOPBACK_EN, write 0x3C then read -> read returns 0x3C; without it, rxf_n stays 1.

Source files
------------

// File: rtl/ftdi_emu_pkg.sv
// rtl/ftdi_emu_pkg.sv - FSM state types and default strobe gap lengths for the FT245 FIFO emulator
package ftdi_emu_pkg;

    typedef enum logic [1:0] {
        R_IDLE,
        R_DRIVE,
        R_GAP
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_STROBE,
        W_GAP
    } wr_state_t;

    localparam int DEF_DEPTH   = 16;
    localparam int DEF_RXF_GAP = 3;
    localparam int DEF_TXE_GAP = 3;

endpackage

// File: rtl/ftdi_emu_fifo.sv
// rtl/ftdi_emu_fifo.sv - synchronous first-word-fall-through byte FIFO with wrap-bit pointers
module ftdi_emu_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ftdi_fifo_emu.sv
// rtl/ftdi_fifo_emu.sv - FT245-style device-side FIFO emulator; FTDI_EMU_LOOPBACK_EN mirrors host writes into RX
module ftdi_fifo_emu
    import ftdi_emu_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int RXF_GAP = DEF_RXF_GAP,
    parameter int TXE_GAP = DEF_TXE_GAP
) (
    input  logic       in_ext_osc,
    input  logic       in_reset,
    inout  wire  [7:0] io_ftdi_data,
    input  logic       in_ftdi_rd_n,
    input  logic       in_ftdi_wr_n,
    output logic       out_ftdi_rxf_n,
    output logic       out_ftdi_txe_n,
    input  logic       in_load_valid,
    input  logic [7:0] in_load_data,
    output logic       out_load_ready,
    output logic       out_drain_valid,
    output logic [7:0] out_drain_data,
    input  logic       in_drain_ready
);

    localparam logic [7:0] RXF_LAST = 8'(RXF_GAP - 1);
    localparam logic [7:0] TXE_LAST = 8'(TXE_GAP - 1);

    rd_state_t  r_state, r_next;
    wr_state_t  w_state, w_next;
    logic [7:0] r_cnt, r_cnt_next, w_cnt, w_cnt_next;
    logic [1:0] rd_sync, wr_sync, sync_fill;
    logic       rd_prev, wr_prev, rd_armed, wr_armed;
    logic       rd_fall, rd_rise, wr_fall, wr_rise;
    logic [7:0] wr_latch, rx_head, rx_push_data;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic       lb_push, bus_oe;

    // A strobe held low through reset must go high before its falling edge counts,
    // so edges are armed only once the synchronizers hold real host samples.
    always_ff @(posedge in_ext_osc) begin
        if (in_reset) begin
            rd_sync   <= 2'b11;
            wr_sync   <= 2'b11;
            rd_prev   <= 1'b1;
            wr_prev   <= 1'b1;
            sync_fill <= 2'b00;
            rd_armed  <= 1'b0;
            wr_armed  <= 1'b0;
        end else begin
            rd_sync   <= {rd_sync[0], in_ftdi_rd_n};
            wr_sync   <= {wr_sync[0], in_ftdi_wr_n};
            rd_prev   <= rd_sync[1];
            wr_prev   <= wr_sync[1];
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && rd_sync[1]) rd_armed <= 1'b1;
            if (sync_fill[1] && wr_sync[1]) wr_armed <= 1'b1;
        end
    end

    assign rd_fall = rd_armed & rd_prev & ~rd_sync[1];
    assign rd_rise = ~rd_prev & rd_sync[1];
    assign wr_fall = wr_armed & wr_prev & ~wr_sync[1];
    assign wr_rise = ~wr_prev & wr_sync[1];

    always_ff @(posedge in_ext_osc) begin
        if (!wr_sync[1]) wr_latch <= io_ftdi_data;
    end

    always_ff @(posedge in_ext_osc) begin
        if (in_reset) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
            r_cnt   <= '0;
            w_cnt   <= '0;
        end else begin
            r_state <= r_next;
            w_state <= w_next;
            r_cnt   <= r_cnt_next;
            w_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        r_next         = r_state;
        r_cnt_next     = '0;
        rx_pop         = 1'b0;
        bus_oe         = 1'b0;
        out_ftdi_rxf_n = 1'b1;
        unique case (r_state)
            R_IDLE: begin
                out_ftdi_rxf_n = rx_empty;
                if (rd_fall && !rx_empty) r_next = R_DRIVE;
            end
            R_DRIVE: begin
                out_ftdi_rxf_n = 1'b0;
                if (rd_rise) begin
                    rx_pop = 1'b1;
                    r_next = R_GAP;
                end else begin
                    bus_oe = !in_reset;
                end
            end
            R_GAP: begin
                if (r_cnt == RXF_LAST) r_next = R_IDLE;
                else                   r_cnt_next = r_cnt + 1'b1;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_next         = w_state;
        w_cnt_next     = '0;
        tx_push        = 1'b0;
        out_ftdi_txe_n = 1'b1;
        unique case (w_state)
            W_IDLE: begin
                out_ftdi_txe_n = tx_full;
                if (wr_fall && !tx_full) w_next = W_STROBE;
            end
            W_STROBE: begin
                out_ftdi_txe_n = 1'b0;
                if (wr_rise) begin
                    tx_push = 1'b1;
                    w_next  = W_GAP;
                end
            end
            W_GAP: begin
                if (w_cnt == TXE_LAST) w_next = W_IDLE;
                else                   w_cnt_next = w_cnt + 1'b1;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign io_ftdi_data = bus_oe ? rx_head : 8'hzz;

`ifdef FTDI_EMU_LOOPBACK_EN
    assign lb_push = tx_push & ~rx_full;
`else
    assign lb_push = 1'b0;
`endif

    assign out_load_ready  = ~rx_full & ~lb_push;
    assign rx_push         = lb_push | (in_load_valid & out_load_ready);
    assign rx_push_data    = lb_push ? wr_latch : in_load_data;
    assign out_drain_valid = ~tx_empty;
    assign tx_pop          = out_drain_valid & in_drain_ready;

    ftdi_emu_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk       (in_ext_osc),
        .reset     (in_reset),
        .push      (rx_push),
        .push_data (rx_push_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    ftdi_emu_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk       (in_ext_osc),
        .reset     (in_reset),
        .push      (tx_push),
        .push_data (wr_latch),
        .pop       (tx_pop),
        .head      (out_drain_data),
        .full      (tx_full),
        .empty     (tx_empty)
    );

endmodule
